// File: rtl/regfile_wb_arbiter_if.sv
// Write-back bus between the ALU/load requesters, the arbiter and the register file.
// The slave view belongs to the arbiter; the master view belongs to the environment.
interface regfile_wb_arbiter_if;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_reg;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_reg;
  logic [31:0] mem_data;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [31:0] pending;

  modport slave (
    input  alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    output alu_ready, mem_ready, reg_write, write_register, write_data, pending
  );

  modport master (
    output alu_valid, alu_reg, alu_data, mem_valid, mem_reg, mem_data,
    input  alu_ready, mem_ready, reg_write, write_register, write_data, pending
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Serialises ALU and load write-backs onto the single register-file write port,
// keeping per-register write order and exporting a pending-write mask for hazard logic.
module regfile_wb_arbiter #(
  parameter bit PRIORITY_MODE = 1'b0
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int ALU = 0;
  localparam int MEM = 1;

  logic [1:0]  req_valid;
  logic [4:0]  req_addr [2];
  logic [31:0] req_data [2];
  logic [1:0]  req_ready;
  logic [1:0]  req_load;
  logic [1:0]  grant;

  logic [1:0]  hold_valid;
  logic [4:0]  hold_addr [2];
  logic [31:0] hold_data [2];

  logic        mem_older_reg;
  logic        mem_older_next;
  logic        last_mem_reg;
  logic        last_mem_next;

  logic        reg_write_reg;
  logic        reg_write_next;
  logic [4:0]  write_register_reg;
  logic [31:0] write_data_reg;
  logic [31:0] pending_mask;

  assign req_valid     = {bus.mem_valid, bus.alu_valid};
  assign req_addr[ALU] = bus.alu_reg;
  assign req_addr[MEM] = bus.mem_reg;
  assign req_data[ALU] = bus.alu_data;
  assign req_data[MEM] = bus.mem_data;

  // A same-register pair always goes oldest first so the register file sees
  // writes in acceptance order; only distinct registers are subject to policy.
  always_comb begin
    grant = 2'b00;
    if (&hold_valid) begin
      if (hold_addr[ALU] == hold_addr[MEM]) begin
        grant[MEM] = mem_older_reg;
      end else if (PRIORITY_MODE) begin
        grant[MEM] = 1'b1;
      end else begin
        grant[MEM] = !last_mem_reg;
      end
      grant[ALU] = !grant[MEM];
    end else begin
      grant = hold_valid;
    end
  end

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_hold
    logic        valid_reg;
    logic [4:0]  addr_reg;
    logic [31:0] data_reg;

    assign req_ready[gi] = rst_n && (!valid_reg || grant[gi]);
    // Register 0 completes the handshake but is never stored.
    assign req_load[gi]  = req_valid[gi] && req_ready[gi] && (req_addr[gi] != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_reg <= 1'b0;
        addr_reg  <= 5'd0;
        data_reg  <= 32'd0;
      end else if (req_load[gi]) begin
        valid_reg <= 1'b1;
        addr_reg  <= req_addr[gi];
        data_reg  <= req_data[gi];
      end else if (grant[gi]) begin
        valid_reg <= 1'b0;
      end
    end

    assign hold_valid[gi] = valid_reg;
    assign hold_addr[gi]  = addr_reg;
    assign hold_data[gi]  = data_reg;
  end

  // A fresh ALU entry is younger than whatever HM keeps, and a simultaneous
  // double load also leaves HM older, so any ALU load marks HM as older.
  always_comb begin
    mem_older_next = mem_older_reg;
    if (req_load[ALU]) begin
      mem_older_next = 1'b1;
    end else if (req_load[MEM]) begin
      mem_older_next = 1'b0;
    end
    last_mem_next = last_mem_reg;
    if (&hold_valid) begin
      last_mem_next = grant[MEM];
    end
    reg_write_next = |grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_older_reg <= 1'b0;
      last_mem_reg  <= 1'b0;
    end else begin
      mem_older_reg <= mem_older_next;
      last_mem_reg  <= last_mem_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_reg      <= 1'b0;
      write_register_reg <= 5'd0;
      write_data_reg     <= 32'd0;
    end else begin
      reg_write_reg <= reg_write_next;
      if (grant[MEM]) begin
        write_register_reg <= hold_addr[MEM];
        write_data_reg     <= hold_data[MEM];
      end else if (grant[ALU]) begin
        write_register_reg <= hold_addr[ALU];
        write_data_reg     <= hold_data[ALU];
      end
    end
  end

  for (gi = 0; gi < 32; gi++) begin : g_pending
    if (gi == 0) begin : g_zero
      assign pending_mask[gi] = 1'b0;
    end else begin : g_live
      assign pending_mask[gi] =
          (hold_valid[ALU] && (hold_addr[ALU] == 5'(gi))) ||
          (hold_valid[MEM] && (hold_addr[MEM] == 5'(gi))) ||
          (reg_write_reg   && (write_register_reg == 5'(gi)));
    end
  end

  assign bus.alu_ready      = req_ready[ALU];
  assign bus.mem_ready      = req_ready[MEM];
  assign bus.reg_write      = reg_write_reg;
  assign bus.write_register = write_register_reg;
  assign bus.write_data     = write_data_reg;
  assign bus.pending        = pending_mask;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: round-robin and fixed-priority instances share stimulus,
// each checked by a scoreboard fed from an abstract reference model.
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        alu_valid, mem_valid;
  logic [4:0]  alu_reg, mem_reg;
  logic [31:0] alu_data, mem_data;

  regfile_wb_arbiter_if if0 ();
  regfile_wb_arbiter_if if1 ();

  assign if0.alu_valid = alu_valid;  assign if1.alu_valid = alu_valid;
  assign if0.alu_reg   = alu_reg;    assign if1.alu_reg   = alu_reg;
  assign if0.alu_data  = alu_data;   assign if1.alu_data  = alu_data;
  assign if0.mem_valid = mem_valid;  assign if1.mem_valid = mem_valid;
  assign if0.mem_reg   = mem_reg;    assign if1.mem_reg   = mem_reg;
  assign if0.mem_data  = mem_data;   assign if1.mem_data  = mem_data;

  regfile_wb_arbiter #(.PRIORITY_MODE(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  regfile_wb_arbiter #(.PRIORITY_MODE(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  logic        rw  [2];
  logic [4:0]  wr  [2];
  logic [31:0] wd  [2];
  logic [31:0] pd  [2];
  logic        rda [2];
  logic        rdm [2];
  assign rw[0] = if0.reg_write;      assign rw[1] = if1.reg_write;
  assign wr[0] = if0.write_register; assign wr[1] = if1.write_register;
  assign wd[0] = if0.write_data;     assign wd[1] = if1.write_data;
  assign pd[0] = if0.pending;        assign pd[1] = if1.pending;
  assign rda[0] = if0.alu_ready;     assign rda[1] = if1.alu_ready;
  assign rdm[0] = if0.mem_ready;     assign rdm[1] = if1.mem_ready;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model per instance k: holding entries [k][0]=alu, [k][1]=mem,
  // age is a global load sequence number, plus the write currently issuing.
  bit          hv [2][2];
  logic [4:0]  hr [2][2];
  logic [31:0] hd [2][2];
  int          hs [2][2];
  bit          last_mem [2];
  bit          ov [2];
  logic [4:0]  orr [2];
  bit          acc_a [2];
  bit          acc_m [2];
  int          seq = 0;
  logic [36:0] exp0 [$];
  logic [36:0] exp1 [$];
  logic [4:0]  seen0 [$];
  logic [4:0]  seen1 [$];

  function automatic int mgrant(input int k);
    if (hv[k][0] && hv[k][1]) begin
      if (hr[k][0] == hr[k][1]) return (hs[k][0] < hs[k][1]) ? 0 : 1;
      if (k == 1) return 1;
      return last_mem[k] ? 0 : 1;
    end
    if (hv[k][0]) return 0;
    if (hv[k][1]) return 1;
    return -1;
  endfunction

  function automatic logic [31:0] mpend(input int k);
    logic [31:0] p;
    p = '0;
    for (int r = 0; r < 2; r++) if (hv[k][r]) p[hr[k][r]] = 1'b1;
    if (ov[k]) p[orr[k]] = 1'b1;
    return p;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      hv[k][0] = 0; hv[k][1] = 0; last_mem[k] = 0; ov[k] = 0;
      acc_a[k] = 0; acc_m[k] = 0;
    end
    exp0.delete();
    exp1.delete();
  endtask

  task automatic model_step(input int k);
    int g;
    bit both, ra, rm;
    g    = mgrant(k);
    both = hv[k][0] && hv[k][1];
    ra   = !hv[k][0] || (g == 0);
    rm   = !hv[k][1] || (g == 1);
    ov[k] = 0;
    if (g >= 0) begin
      if (k == 0) exp0.push_back({hr[k][g], hd[k][g]});
      else        exp1.push_back({hr[k][g], hd[k][g]});
      ov[k] = 1;
      orr[k] = hr[k][g];
      hv[k][g] = 0;
      if (both) last_mem[k] = (g == 1);
    end
    acc_m[k] = mem_valid && rm;
    acc_a[k] = alu_valid && ra;
    if (acc_m[k] && mem_reg != 5'd0) begin
      hv[k][1] = 1; hr[k][1] = mem_reg; hd[k][1] = mem_data; hs[k][1] = seq; seq++;
    end
    if (acc_a[k] && alu_reg != 5'd0) begin
      hv[k][0] = 1; hr[k][0] = alu_reg; hd[k][0] = alu_data; hs[k][0] = seq; seq++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    alu_valid = 0;
    mem_valid = 0;
    repeat (n) cyc();
  endtask

  // Monitor: compares each presented write against the scoreboard queue.
  initial begin
    logic [36:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int k = 0; k < 2; k++) begin
          check($sformatf("alu_ready[%0d]", k), 32'(rda[k]), 32'(!hv[k][0] || mgrant(k) == 0));
          check($sformatf("mem_ready[%0d]", k), 32'(rdm[k]), 32'(!hv[k][1] || mgrant(k) == 1));
          check($sformatf("pending[%0d]", k), pd[k], mpend(k));
          if (rw[k] === 1'b1) begin
            if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_write[%0d]: got reg %0d data %h expected no write", k, wr[k], wd[k]);
            end else begin
              e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
              check($sformatf("write_register[%0d]", k), 32'(wr[k]), 32'(e[36:32]));
              check($sformatf("write_data[%0d]", k), wd[k], e[31:0]);
              if (k == 0) seen0.push_back(wr[k]);
              else        seen1.push_back(wr[k]);
            end
          end
        end
      end
    end
  end

  initial begin
    int ai, mi;
    rst_n = 0;
    alu_valid = 0; mem_valid = 0;
    alu_reg = 0; mem_reg = 0; alu_data = 0; mem_data = 0;
    model_clear();
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_reg_write[%0d]", k), 32'(rw[k]), 32'd0);
      check($sformatf("rst_write_register[%0d]", k), 32'(wr[k]), 32'd0);
      check($sformatf("rst_write_data[%0d]", k), wd[k], 32'd0);
      check($sformatf("rst_pending[%0d]", k), pd[k], 32'd0);
      check($sformatf("rst_alu_ready[%0d]", k), 32'(rda[k]), 32'd0);
      check($sformatf("rst_mem_ready[%0d]", k), 32'(rdm[k]), 32'd0);
    end
    #2 rst_n = 1;

    // Single ALU write with latency checks.
    alu_valid = 1; alu_reg = 5'd5; alu_data = 32'hDEADBEEF;
    cyc();
    alu_valid = 0;
    check("single_pending_t", 32'(if0.pending[5]), 32'd1);
    cyc();
    check("single_reg_write", 32'(if0.reg_write), 32'd1);
    check("single_write_register", 32'(if0.write_register), 32'd5);
    check("single_write_data", if0.write_data, 32'hDEADBEEF);
    cyc();
    check("single_pending_t2", if0.pending, 32'd0);
    idle(3);

    // Both streaming, distinct registers, round-robin order.
    seen0.delete();
    ai = 0; mi = 0;
    for (int c = 0; c < 12; c++) begin
      alu_valid = (ai < 4); alu_reg = 5'(1 + ai); alu_data = $urandom;
      mem_valid = (mi < 4); mem_reg = 5'(9 + mi); mem_data = $urandom;
      cyc();
      if (acc_a[0] && ai < 4) ai++;
      if (acc_m[0] && mi < 4) mi++;
    end
    idle(3);
    check("rr_count", seen0.size(), 32'd8);
    for (int i = 0; i < 8 && i < seen0.size(); i++)
      check($sformatf("rr_order[%0d]", i), 32'(seen0[i]), (i % 2 == 0) ? 32'(9 + i / 2) : 32'(1 + i / 2));

    // Same-register ordering: ALU 7=1 then load 7=2.
    alu_valid = 1; alu_reg = 5'd7; alu_data = 32'h1;
    cyc();
    alu_valid = 0;
    mem_valid = 1; mem_reg = 5'd7; mem_data = 32'h2;
    cyc();
    mem_valid = 0;
    check("order_pending_a", 32'(if0.pending[7]), 32'd1);
    cyc();
    check("order_pending_b", 32'(if0.pending[7]), 32'd1);
    check("order_second_data", if0.write_data, 32'h2);
    cyc();
    check("order_pending_clear", 32'(if0.pending[7]), 32'd0);
    idle(2);

    // Register 0 writes are accepted and dropped.
    alu_valid = 1; alu_reg = 5'd0; alu_data = 32'h12345678;
    check("r0_ready", 32'(if0.alu_ready), 32'd1);
    cyc();
    alu_valid = 0;
    check("r0_pending", if0.pending, 32'd0);
    cyc();
    check("r0_no_write", 32'(if0.reg_write), 32'd0);
    idle(2);

    // Fixed priority: ten loads starve the held ALU write.
    seen1.delete();
    alu_valid = 1; alu_reg = 5'd3; alu_data = 32'hA5A5A5A5;
    for (int c = 0; c < 10; c++) begin
      mem_valid = 1; mem_reg = 5'(20 + c); mem_data = $urandom;
      cyc();
      check($sformatf("prio_alu_ready[%0d]", c), 32'(if1.alu_ready), 32'd0);
    end
    alu_valid = 0; mem_valid = 0;
    idle(4);
    check("prio_count", seen1.size(), 32'd11);
    for (int i = 0; i < 11 && i < seen1.size(); i++)
      check($sformatf("prio_order[%0d]", i), 32'(seen1[i]), (i < 10) ? 32'(20 + i) : 32'd3);

    // Asynchronous reset with everything full.
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1; alu_reg = 5'(1 + c); alu_data = $urandom;
      mem_valid = 1; mem_reg = 5'(16 + c); mem_data = $urandom;
      cyc();
    end
    check("mid_full_reg_write", 32'(if0.reg_write), 32'd1);
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("mid_reg_write[%0d]", k), 32'(rw[k]), 32'd0);
      check($sformatf("mid_pending[%0d]", k), pd[k], 32'd0);
      check($sformatf("mid_alu_ready[%0d]", k), 32'(rda[k]), 32'd0);
    end
    model_clear();
    alu_valid = 0; mem_valid = 0;
    @(negedge clk);
    #2 rst_n = 1;
    alu_valid = 1; alu_reg = 5'd6; alu_data = 32'hCAFEF00D;
    cyc();
    alu_valid = 0;
    check("post_rst_edge1", 32'(if0.reg_write), 32'd0);
    cyc();
    check("post_rst_edge2", 32'(if0.reg_write), 32'd1);
    check("post_rst_reg", 32'(if0.write_register), 32'd6);
    idle(2);

    // Random traffic with frequent register collisions.
    for (int c = 0; c < 400; c++) begin
      alu_valid = ($urandom_range(0, 9) < 6); alu_reg = 5'($urandom_range(0, 7)); alu_data = $urandom;
      mem_valid = ($urandom_range(0, 9) < 6); mem_reg = 5'($urandom_range(0, 7)); mem_data = $urandom;
      cyc();
    end
    idle(5);
    check("drain_q0", exp0.size(), 32'd0);
    check("drain_q1", exp1.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
